sysid_info_regs: RTL and testbench
==================================

// Module: sysid_info_regs
// PURPOSE
//  Parametrised system-ID/info slave: the next generation of the constant sysid slave on the Nios II bus.
//  Adds a free-running uptime counter with an atomic 64-bit read, a byte-writable scratch register
//  and a parameter word, and returns data over a pipelined read path (readdatavalid, configurable latency).
//  Sits on the Avalon-MM interconnect beside the other peripheral slaves; software uses it to identify the build.
// PARAMETERS
//  SYS_ID         32'h0000_0000   value returned at word 0
//  TIMESTAMP      32'd1457386793  build timestamp returned at word 1
//  ADDR_W         3               word-address width; must be >= 3
//  READ_LATENCY   1               cycles from accepted read to readdatavalid; legal range 1..4
//  UPTIME_W       64              uptime counter width; legal range 33..64
//  SCRATCH_RESET  32'h0000_0000   scratch register value after reset
// PORTS
//  clock          in   1          system clock; all logic on the rising edge
//  reset          in   1          synchronous, active-high reset
//  address        in   ADDR_W     word address
//  read           in   1          read strobe; one read accepted per cycle, never stalled
//  write          in   1          write strobe
//  writedata      in   32         write data
//  byteenable     in   4          byte lanes for writes
//  readdata       out  32         read data; valid only when readdatavalid=1
//  readdatavalid  out  1          one-cycle pulse per accepted read
// BEHAVIOUR
//  Synchronous reset: counter=0, shadow=0, scratch=SCRATCH_RESET, read pipeline flushed,
//   readdatavalid=0, readdata=0. A read accepted in the cycle reset is high is dropped (no valid).
//  Register map (word addresses):
//   0 SYS_ID (RO)  1 TIMESTAMP (RO)  2 UPTIME_LO (RO)  3 UPTIME_HI_SHADOW (RO)
//   4 SCRATCH (RW) 5 CTRL (WO; reads 0)  6 PARAM (RO)  7 and above: reserved, read 0
//  Uptime counter: increments by 1 every clock not in reset or clear; wraps to 0 at all-ones.
//   Bits above UPTIME_W read as 0.
//  Atomic read: a read of word 2 at cycle T returns counter[31:0] as registered at T.
//   The same edge copies counter[UPTIME_W-1:32] into the shadow; word 3 returns the shadow,
//   which changes only when word 2 is read.
//  CTRL write with writedata[0]=1 and byteenable[0]=1 at cycle T: counter=0 after edge T
//   (a read of word 2 at T+1 returns 0). The shadow is unaffected. All other CTRL bits are ignored.
//  SCRATCH: each byte lane i is written when byteenable[i]=1. Disabled lanes hold their value.
//  PARAM = {8'(READ_LATENCY), 8'(ADDR_W), 8'(UPTIME_W), 8'h02}; the low byte is the block revision.
//  Writes to RO and reserved words are ignored without error.
//  Read pipeline:
//   - Data is selected from state at acceptance cycle T.
//   - readdatavalid=1 and readdata are driven in cycle T+READ_LATENCY.
//   - Back-to-back reads produce back-to-back valids, in order.
//   - readdata=0 whenever readdatavalid=0.
//  read and write both high in one cycle: only the write is performed; no valid is generated.
//  Write then read of the same word on consecutive cycles returns the new value.
//  Reset mid-pipeline: all in-flight reads are discarded; no valid pulses after reset.
// TESTING
//  1 Reset, then read words 0, 1, 6 with READ_LATENCY=1 -> valid at T+1 with SYS_ID,
//    32'd1457386793, 32'h0103_4002.
//  2 Write 32'hDEAD_BEEF with be=4'b1111 to word 4, then write 32'h0000_0055 with be=4'b0001
//    -> word 4 reads 32'hDEAD_BE55. After reset it reads SCRATCH_RESET.
//  3 Force counter to 64'h0000_0000_FFFF_FFFE. Read word 2 at T -> 32'hFFFF_FFFE.
//    Read word 3 at T+5 -> 32'h0. A second read of word 2 when low=2 -> word 3 reads 32'h1.
//  4 Write CTRL=1 at T, read word 2 at T+1 -> 0; read word 2 at T+4 -> 3.
//    CTRL=2 or be=4'b0000 -> no clear.
//  5 READ_LATENCY=3, reads on 4 consecutive cycles (words 0,1,4,7) -> 4 consecutive valids
//    starting at T+3, in order, last = 0. Assert reset at T+2 -> no valids appear.
//  6 read=write=1 on word 4 -> scratch updated, readdatavalid stays 0.
//    Counter at all-ones (UPTIME_W=33) wraps to 0 on the next edge.

Source files
------------

// File: rtl/sysid_info_regs_if.sv
// Avalon-MM slave bus between the interconnect and sysid_info_regs.
// readdata/readdatavalid return on a fixed-latency pipelined read path.
interface sysid_info_regs_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_info_regs.sv
// System-ID/info slave: constant ID words, free-running uptime counter with an
// atomic 64-bit read via a high-half shadow, byte-writable scratch, pipelined reads.
module sysid_info_regs #(
  parameter logic [31:0] SYS_ID        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'd1457386793,
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned UPTIME_W      = 64,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input logic              clock,
  input logic              reset,
  sysid_info_regs_if.slave bus
);

  localparam int unsigned HI_W = UPTIME_W - 32;

  localparam logic [ADDR_W-1:0] ADDR_SYSID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_UPLO    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_UPHI    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_PARAM   = ADDR_W'(6);

  // Low byte is the block revision.
  localparam logic [31:0] PARAM_WORD =
    {8'(READ_LATENCY), 8'(ADDR_W), 8'(UPTIME_W), 8'h02};

  logic [UPTIME_W-1:0]     uptime_q, uptime_d;
  logic [HI_W-1:0]         shadow_q, shadow_d;
  logic [31:0]             scratch_q, scratch_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [31:0]             dat_d [READ_LATENCY];

  logic        rd_acc;
  logic        wr_scratch;
  logic        wr_clear;
  logic [31:0] rd_word;

  // A simultaneous write wins; the read is not accepted and produces no valid.
  always_comb begin
    rd_acc     = bus.read && !bus.write;
    wr_scratch = bus.write && (bus.address == ADDR_SCRATCH);
    wr_clear   = bus.write && (bus.address == ADDR_CTRL) &&
                 bus.byteenable[0] && bus.writedata[0];
  end

  // Read data selected from current state in the acceptance cycle.
  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_SYSID:   rd_word = SYS_ID;
      ADDR_TSTAMP:  rd_word = TIMESTAMP;
      ADDR_UPLO:    rd_word = uptime_q[31:0];
      ADDR_UPHI:    rd_word = 32'(shadow_q);
      ADDR_SCRATCH: rd_word = scratch_q;
      ADDR_PARAM:   rd_word = PARAM_WORD;
      default:      rd_word = '0;
    endcase
  end

  // Counter, shadow and scratch next-state.
  always_comb begin
    uptime_d  = wr_clear ? '0 : uptime_q + UPTIME_W'(1);
    shadow_d  = shadow_q;
    scratch_d = scratch_q;
    if (rd_acc && (bus.address == ADDR_UPLO)) begin
      shadow_d = uptime_q[UPTIME_W-1:32];
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_scratch && bus.byteenable[i]) begin
        scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
      end
    end
  end

  // Read pipeline; data stages carry zero when no read is in flight.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? rd_word : 32'h0;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q  <= '0;
      shadow_q  <= '0;
      scratch_q <= SCRATCH_RESET;
      vld_q     <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      uptime_q  <= uptime_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      vld_q     <= vld_d;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign bus.readdatavalid = vld_q[READ_LATENCY-1];
  assign bus.readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: two instances (latency 1 / 64-bit uptime, latency 3 / 33-bit uptime),
// expected read results queued per instance at issue and checked when readdatavalid pulses.
module tb_sysid_info_regs;

  localparam logic [31:0] SYS_ID0 = 32'h1234_ABCD;
  localparam logic [31:0] TS0     = 32'd1457386793;
  localparam logic [31:0] SYS_ID1 = 32'h5151_D00D;
  localparam logic [31:0] TS1     = 32'h6543_2100;
  localparam logic [31:0] SCR1    = 32'hA5A5_0F0F;
  localparam int          NVEC    = 21;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          tag;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   cyc  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   drain   = 0;
  bit   mon_en    = 1'b0;
  bit   stim_done = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl [NVEC];

  sysid_info_regs_if #(.ADDR_W(3)) b0 ();
  sysid_info_regs_if #(.ADDR_W(4)) b1 ();

  sysid_info_regs #(
    .SYS_ID(SYS_ID0)
  ) dut0 (
    .clock(clk),
    .reset(rst0),
    .bus  (b0)
  );

  sysid_info_regs #(
    .SYS_ID       (SYS_ID1),
    .TIMESTAMP    (TS1),
    .ADDR_W       (4),
    .READ_LATENCY (3),
    .UPTIME_W     (33),
    .SCRATCH_RESET(SCR1)
  ) dut1 (
    .clock(clk),
    .reset(rst1),
    .bus  (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_bus();
    b0.read = 1'b0; b0.write = 1'b0; b0.address = '0; b0.writedata = '0; b0.byteenable = '0;
    b1.read = 1'b0; b1.write = 1'b0; b1.address = '0; b1.writedata = '0; b1.byteenable = '0;
  endtask

  // Start a new bus cycle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic rd(input int d, input logic [3:0] a, input logic [31:0] e, input int tag);
    if (d == 0) begin
      b0.read = 1'b1;
      b0.address = 3'(a);
      q0.push_back('{data: e, due: cyc + 1, tag: tag});
    end else begin
      b1.read = 1'b1;
      b1.address = a;
      q1.push_back('{data: e, due: cyc + 3, tag: tag});
    end
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      b0.write = 1'b1; b0.address = 3'(a); b0.writedata = wd; b0.byteenable = be;
    end else begin
      b1.write = 1'b1; b1.address = a; b1.writedata = wd; b1.byteenable = be;
    end
  endtask

  task automatic check_port(input int d, input logic v, input logic [31:0] rdata);
    exp_t e;
    n_tests++;
    if (v) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_fail++;
        $display("FAIL dut%0d unexpected_valid: got valid data=%h at cyc %0d, required no valid",
                 d, rdata, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (rdata !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL dut%0d read_tag%0d: got data=%h at cyc %0d, required data=%h at cyc %0d",
                   d, e.tag, rdata, cyc, e.data, e.due);
        end
      end
    end else if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL dut%0d idle_readdata: got %h at cyc %0d, required 00000000", d, rdata, cyc);
    end
  endtask

  // Output monitor, sampled mid-cycle; also owns the end-of-run checks.
  always @(negedge clk) begin
    if (mon_en) begin
      check_port(0, b0.readdatavalid, b0.readdata);
      check_port(1, b1.readdatavalid, b1.readdata);
    end
    if (stim_done) begin
      drain++;
      if (drain == 8) begin
        n_tests += 2;
        if (q0.size() != 0) begin
          n_fail++;
          $display("FAIL dut0 missing_valids: got %0d reads outstanding, required 0", q0.size());
        end
        if (q1.size() != 0) begin
          n_fail++;
          $display("FAIL dut1 missing_valids: got %0d reads outstanding, required 0", q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'd0, 32'h0,          4'h0,    SYS_ID0};
    tbl[1]  = '{1'b1, 1'b0, 4'd1, 32'h0,          4'h0,    TS0};
    tbl[2]  = '{1'b1, 1'b0, 4'd6, 32'h0,          4'h0,    32'h0103_4002};
    tbl[3]  = '{1'b1, 1'b0, 4'd4, 32'h0,          4'h0,    32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'd3, 32'h0,          4'h0,    32'h0};
    tbl[5]  = '{1'b0, 1'b1, 4'd4, 32'hDEAD_BEEF,  4'hF,    32'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'd4, 32'h0000_0055,  4'h1,    32'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'd4, 32'h0,          4'h0,    32'hDEAD_BE55};
    tbl[8]  = '{1'b0, 1'b1, 4'd4, 32'h1122_3344,  4'b1010, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 4'd4, 32'h0,          4'h0,    32'h11AD_3355};
    tbl[10] = '{1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF,  4'hF,    32'h0};
    tbl[11] = '{1'b1, 1'b0, 4'd0, 32'h0,          4'h0,    SYS_ID0};
    tbl[12] = '{1'b0, 1'b1, 4'd7, 32'hFFFF_FFFF,  4'hF,    32'h0};
    tbl[13] = '{1'b1, 1'b0, 4'd7, 32'h0,          4'h0,    32'h0};
    tbl[14] = '{1'b1, 1'b0, 4'd5, 32'h0,          4'h0,    32'h0};
    tbl[15] = '{1'b0, 1'b1, 4'd4, 32'hFFFF_FFFF,  4'h0,    32'h0};
    tbl[16] = '{1'b1, 1'b0, 4'd4, 32'h0,          4'h0,    32'h11AD_3355};
    tbl[17] = '{1'b1, 1'b1, 4'd4, 32'h0000_00AA,  4'h1,    32'h0};
    tbl[18] = '{1'b1, 1'b0, 4'd4, 32'h0,          4'h0,    32'h11AD_33AA};
    tbl[19] = '{1'b0, 1'b1, 4'd6, 32'h0,          4'hF,    32'h0};
    tbl[20] = '{1'b1, 1'b0, 4'd6, 32'h0,          4'h0,    32'h0103_4002};

    idle_bus();
    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    mon_en = 1'b1;

    // Register map, byte lanes, RO/reserved writes, read+write collision on dut0.
    for (int i = 0; i < NVEC; i++) begin
      tick();
      if (tbl[i].rd && tbl[i].wr) begin
        b0.read = 1'b1;
        wr(0, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      end else begin
        if (tbl[i].rd) rd(0, tbl[i].addr, tbl[i].exp, i);
        if (tbl[i].wr) wr(0, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      end
    end

    // CTRL clear, then writes that must not clear.
    tick(); wr(0, 4'd5, 32'h1, 4'h1);
    tick(); rd(0, 4'd2, 32'd0, 100);
    tick();
    tick();
    tick(); rd(0, 4'd2, 32'd3, 101);
    tick(); wr(0, 4'd5, 32'h2, 4'hF);
    tick(); rd(0, 4'd2, 32'd5, 102);
    tick(); wr(0, 4'd5, 32'hFFFF_FFFF, 4'h0);
    tick(); rd(0, 4'd2, 32'd7, 103);

    // Atomic 64-bit read across the 32-bit carry; clear leaves the shadow alone.
    tick(); rd(0, 4'd2, 32'hFFFF_FFFE, 110);
    force dut0.uptime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut0.uptime_q;
    tick();
    tick();
    tick(); rd(0, 4'd3, 32'h0, 111);
    tick(); rd(0, 4'd2, 32'h2, 112);
    tick(); rd(0, 4'd3, 32'h1, 113);
    tick(); wr(0, 4'd5, 32'h1, 4'h1);
    tick(); rd(0, 4'd3, 32'h1, 114);
    tick(); rd(0, 4'd2, 32'h1, 115);

    // Reset: read in the reset cycle is dropped, state returns to reset values.
    tick(); rst0 = 1'b1; b0.read = 1'b1; b0.address = 3'd0;
    tick(); rst0 = 1'b0; rd(0, 4'd2, 32'h0, 120);
    tick(); rd(0, 4'd3, 32'h0, 121);
    tick(); rd(0, 4'd4, 32'h0, 122);
    tick(); rd(0, 4'd6, 32'h0103_4002, 123);

    // Latency-3 instance: back-to-back reads and the wider reserved space.
    tick(); rd(1, 4'd0,  SYS_ID1, 200);
    tick(); rd(1, 4'd1,  TS1, 201);
    tick(); rd(1, 4'd4,  SCR1, 202);
    tick(); rd(1, 4'd7,  32'h0, 203);
    tick(); rd(1, 4'd6,  32'h0304_2102, 204);
    tick(); rd(1, 4'd8,  32'h0, 205);
    tick(); rd(1, 4'd15, 32'h0, 206);
    tick(); wr(1, 4'd4, 32'h0, 4'b1100);
    tick(); rd(1, 4'd4, 32'h0000_0F0F, 207);
    tick(); b1.read = 1'b1; wr(1, 4'd4, 32'h1234_5678, 4'hF);
    tick(); rd(1, 4'd4, 32'h1234_5678, 208);

    // 33-bit counter wrap from all-ones.
    tick(); rd(1, 4'd2, 32'hFFFF_FFFF, 210);
    force dut1.uptime_q = 33'h1_FFFF_FFFF;
    #1 release dut1.uptime_q;
    tick(); rd(1, 4'd3, 32'h1, 211);
    tick(); rd(1, 4'd2, 32'h1, 212);
    tick(); rd(1, 4'd3, 32'h0, 213);
    repeat (4) tick();

    // Reset mid-pipeline: none of these four reads may produce a valid.
    tick(); b1.read = 1'b1; b1.address = 4'd0;
    tick(); b1.read = 1'b1; b1.address = 4'd1;
    tick(); rst1 = 1'b1; b1.read = 1'b1; b1.address = 4'd4;
    tick(); b1.read = 1'b1; b1.address = 4'd6;
    tick(); rst1 = 1'b0; rd(1, 4'd2, 32'h0, 220);
    repeat (5) tick();
    tick(); rd(1, 4'd4, SCR1, 221);
    tick();
    stim_done = 1'b1;
  end

endmodule
